// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
//   state_e        - loader FSM states
//   BYTES_PER_WORD - bytes packed into one instruction
//   WORD_W, BYTE_W - instruction and stream byte widths
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready handshake from the program source.
//   i_valid - source has a byte
//   i_byte  - stream data
//   i_last  - final byte of the program (qualified by i_valid)
//   o_ready - loader accepts a byte this cycle
// master: the program source (UART/JTAG bridge); slave: the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              i_valid;
    logic [BYTE_W-1:0] i_byte;
    logic              i_last;
    logic              o_ready;

    modport master (output i_valid, output i_byte, output i_last, input o_ready);
    modport slave  (input i_valid, input i_byte, input i_last, output o_ready);

endinterface

// File: rtl/imem_loader_word_packer.sv
// imem_loader_word_packer: packs accepted stream bytes little-endian into one word.
//   clk, rst_n  - clock, async active-low reset
//   clear       - drop the byte count, assembled word and last flag
//   accept      - store in_byte into the next byte lane
//   in_byte     - byte to store
//   in_last     - accepted byte is the final program byte
//   word        - assembled word (unfilled lanes read zero)
//   final_slot  - next accepted byte completes the word
//   last        - current word carried the final program byte
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_last,
    output logic [WORD_W-1:0] word,
    output logic              final_slot,
    output logic              last
);

    localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        last_d = last_q;
        if (clear) begin
            cnt_d  = '0;
            word_d = '0;
            last_d = 1'b0;
        end else if (accept) begin
            word_d[cnt_q*BYTE_W +: BYTE_W] = in_byte;
            cnt_d  = cnt_q + 1'b1;
            last_d = last_q | in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            last_q <= last_d;
        end
    end

    assign word       = word_q;
    assign final_slot = (cnt_q == CntW'(BYTES_PER_WORD - 1));
    assign last       = last_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory write port. Packs a byte stream
// into 32-bit words, writes them to consecutive word addresses and holds the core in reset
// until the program is loaded.
//   DEPTH        - instruction memory capacity in words (max words loaded)
//   clk, rst_n   - clock, async active-low reset
//   start        - request a (re)load; honoured in IDLE and DONE only
//   strm         - byte-stream handshake (slave side)
//   o_wr         - one-cycle write strobe
//   o_addr       - byte address of the write (word index << 2)
//   o_inst       - packed instruction
//   o_busy       - loading or writing
//   o_done       - program loaded
//   o_err        - sticky: partial last word or capacity reached without i_last
//   o_cpu_rst_n  - core reset, released only in DONE
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.slave      strm,
    output logic              o_wr,
    output logic [WORD_W-1:0] o_addr,
    output logic [WORD_W-1:0] o_inst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_cpu_rst_n
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              err_q, err_d;
    logic              accept;
    logic              pk_clear;
    logic              pk_final;
    logic              pk_last;
    logic [WORD_W-1:0] pk_word;

    assign accept = (state_q == StLoad) && strm.i_valid;

    imem_loader_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .accept     (accept),
        .in_byte    (strm.i_byte),
        .in_last    (strm.i_last),
        .word       (pk_word),
        .final_slot (pk_final),
        .last       (pk_last)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StLoad;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
                end
            end
            StLoad: begin
                if (accept && (pk_final || strm.i_last)) begin
                    state_d = StWrite;
                    // i_last before the 4th byte leaves a zero-padded word.
                    if (strm.i_last && !pk_final) begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                // Packer is cleared on the edge leaving WRITE, so o_inst holds during it.
                pk_clear = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (pk_last) begin
                    state_d = StDone;
                end else if (idx_q == IdxW'(DEPTH - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign strm.o_ready = (state_q == StLoad);
    assign o_wr         = (state_q == StWrite);
    assign o_addr       = {{(WORD_W - IdxW - 2){1'b0}}, idx_q, 2'b00};
    assign o_inst       = pk_word;
    assign o_busy       = (state_q == StLoad) || (state_q == StWrite);
    assign o_done       = (state_q == StDone);
    assign o_err        = err_q;
    assign o_cpu_rst_n  = (state_q == StDone);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory's write port. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit instructions. It writes each instruction to consecutive word addresses and holds the CPU core in reset until the program is loaded. It sits between the external program source (UART/JTAG bridge) and the `wr`/`addr`/`i_inst` port of the instruction memory.

## Interface
- `DEPTH`, default 10: instruction memory capacity in 32-bit words; maximum number of words loaded.
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request a (re)load; sampled in IDLE and DONE only.
- `i_valid` input 1: byte-stream valid.
- `i_byte` input 8: stream data.
- `i_last` input 1: qualifies the final byte of the program; meaningful only with `i_valid`.
- `o_ready` output 1: loader accepts a byte this cycle.
- `o_wr` output 1: one-cycle write strobe to instruction memory.
- `o_addr` output 32: byte address of the write (word index << 2).
- `o_inst` output 32: packed instruction.
- `o_busy` output 1: high in LOAD or WRITE.
- `o_done` output 1: high in DONE.
- `o_err` output 1: sticky error; cleared on the next accepted `start`.
- `o_cpu_rst_n` output 1: core reset, active-low; high only in DONE.

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE. All outputs are registered or decoded from state.
- IDLE → LOAD on `start`. Entering LOAD clears the word index, byte count, assembly register and `o_err`.
- LOAD: `o_ready`=1. A byte is accepted when `i_valid & o_ready`. Byte n (0..3) goes to bits [8n+7:8n].
- LOAD → WRITE after the 4th byte, or on `i_last` at any byte count.
  - On early `i_last` (partial word), unfilled bytes are zero and `o_err` is set.
- WRITE: `o_ready`=0, `o_wr`=1, `o_addr`=index<<2, `o_inst`=assembled word. Then the index increments and the byte count resets.
- WRITE → DONE if this word carried `i_last`, or if index == DEPTH-1.
  - Reaching DEPTH words without `i_last` also sets `o_err`; further bytes are not accepted.
- WRITE → LOAD otherwise.
- DONE: `o_cpu_rst_n`=1, `o_done`=1. DONE → LOAD on `start`, which re-asserts core reset in the same transition.
- `start` in LOAD or WRITE is ignored.
- Index width is clog2(DEPTH). `o_addr` is zero-extended to 32 bits, so addresses never wrap.

## Timing
- Reset values (async, immediate):
  - state IDLE
  - `o_ready`, `o_wr`, `o_busy`, `o_done`, `o_err` = 0
  - `o_addr`, `o_inst` = 0
  - `o_cpu_rst_n` = 0
- `o_wr` pulses exactly in the cycle after the accepting edge of the word's final byte. `o_addr`/`o_inst` are stable during that cycle.
- Peak throughput: 4 bytes per 5 cycles; `i_valid` gaps stall LOAD indefinitely.
- `o_cpu_rst_n` rises in the first DONE cycle, one cycle after the final `o_wr`.
- `start` → `o_ready`=1 on the following cycle.
- `rst_n` asserted mid-load: FSM returns to IDLE and the core stays in reset. Words already written remain in memory; the loader does not clear them.
- Simultaneous `i_last` on the DEPTH-th word: DONE with `o_err`=0.

## Structure
- Shared package:
  - state enum (IDLE/LOAD/WRITE/DONE)
  - `BYTES_PER_WORD`=4
  - `WORD_W`=32
  - `BYTE_W`=8
- Optional sub-module `word_packer`: byte counter plus little-endian shift/assembly register, with accept, clear and full/last outputs. The top level holds the FSM, word index and status flags.

## Test plan
- Full program: reset, `start`, stream 8 bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 with `i_last` on byte 8 → writes 0x00000013@0x0 and 0x00100093@0x4, `o_done`=1, `o_err`=0, `o_cpu_rst_n` rises one cycle after second `o_wr`.
- Partial word: 6 bytes, `i_last` on 6th → second write `o_inst`=0x0000BBAA-style zero padding @0x4, `o_err`=1.
- Overflow: DEPTH=2, stream 12 bytes without `i_last` → exactly 2 writes (0x0, 0x4), `o_ready`=0 afterward, `o_err`=1, DONE.
- Backpressure/gaps: random `i_valid` deassertion and `start` pulses during LOAD → identical memory contents, `start` ignored, `o_ready`=0 during every WRITE cycle.
- Reset mid-load: assert `rst_n`=0 after 3 bytes → all outputs at reset values immediately, no `o_wr`; reload after reset succeeds from address 0.
- Reload from DONE: `start` in DONE → `o_cpu_rst_n` drops next cycle, `o_err` cleared, new image written from 0x0.
